// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: widths, NOP encoding, reset PC
// and the J-type target formation used by the fetch stage.
package mips_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          JIDX_W       = 26;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // J/JAL keep the region bits of the jump's own PC+4 and word-align the index.
    function automatic logic [INSTR_W-1:0] jump_target(
        input logic [INSTR_W-1:0] pc4,
        input logic [JIDX_W-1:0]  idx
    );
        jump_target = {pc4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: squash clears to a NOP bubble, load captures the
// fetched word, otherwise the contents hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               squash_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc4_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] pc4_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc4_q,   pc4_d;

    // Next-state selection; squash outranks load.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (squash_i) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc4_d   = 32'h0000_0000;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc4_d   = pc4_i;
        end else begin
            valid_d = valid_q;
            instr_d = instr_q;
            pc4_d   = pc4_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection (jump > branch >
// stall > PC+4), redirect squash of IF/ID and the sticky misaligned-target flag.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               jump,
    input  logic [JIDX_W-1:0]  jump_index,
    output logic [INSTR_W-1:0] pc_out,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [INSTR_W-1:0] if_id_pc4,
    output logic               misalign_err
);

    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               err_q, err_d;
    logic [INSTR_W-1:0] pc_plus4_s;
    logic               redirect_s;
    logic               load_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign redirect_s = jump | branch_taken;
    assign load_s     = ~stall & ~redirect_s;

    // Next-PC mux; a jump shadows a simultaneous branch entirely, including its alignment check.
    always_comb begin
        pc_d  = pc_plus4_s;
        err_d = err_q;
        if (jump) begin
            pc_d = jump_target(if_id_pc4, jump_index);
        end else if (branch_taken) begin
            pc_d  = {branch_target[31:2], 2'b00};
            err_d = err_q | (branch_target[1:0] != 2'b00);
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // PC and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_s),
        .squash_i (redirect_s),
        .instr_i  (instr_in),
        .pc4_i    (pc_plus4_s),
        .valid_o  (if_id_valid),
        .instr_o  (if_id_instr),
        .pc4_o    (if_id_pc4)
    );

    assign pc_out       = pc_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// control traffic checked against a cycle-level behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_taken, jump;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] pc_out, instr_in, if_id_instr, if_id_pc4;
    logic        if_id_valid, misalign_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_err;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .pc_out        (pc_out),
        .instr_in      (instr_in),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign instr_in = mem_word(pc_out);

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_err = 1'b0;
    endtask

    // Apply one cycle of controls, advance the model by one edge, settle 1 time unit.
    task automatic step(input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [25:0] ji);
        logic [31:0] npc;
        stall = st; branch_taken = br; branch_target = bt; jump = j; jump_index = ji;
        @(posedge clk);
        if (j)       npc = {m_pc4[31:28], ji, 2'b00};
        else if (br) npc = bt & 32'hFFFF_FFFC;
        else if (st) npc = m_pc;
        else         npc = m_pc + 32'd4;
        if (br && !j && (bt % 4 != 0)) m_err = 1'b1;
        if (j || br) begin
            m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        end else if (!st) begin
            m_valid = 1'b1; m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4;
        end
        m_pc = npc;
        #1;
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = 32'h0; jump_index = 26'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests_run += 5;
        if (pc_out !== 32'h0)       begin tests_failed++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
        if (if_id_valid !== 1'b0)   begin tests_failed++; $display("FAIL reset_valid got %b exp 0", if_id_valid); end
        if (if_id_instr !== 32'h0)  begin tests_failed++; $display("FAIL reset_instr got %h exp 0", if_id_instr); end
        if (if_id_pc4 !== 32'h0)    begin tests_failed++; $display("FAIL reset_pc4 got %h exp 0", if_id_pc4); end
        if (misalign_err !== 1'b0)  begin tests_failed++; $display("FAIL reset_err got %b exp 0", misalign_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
            tests_run += 4;
            if (pc_out !== 32'(4*(i+1)))              begin tests_failed++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_out, 32'(4*(i+1))); end
            if (if_id_valid !== 1'b1)                 begin tests_failed++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_id_valid); end
            if (if_id_instr !== 32'h1000_0000 + i)    begin tests_failed++; $display("FAIL seq_instr[%0d] got %h exp %h", i, if_id_instr, 32'h1000_0000 + i); end
            if (if_id_pc4 !== 32'(4*(i+1)))           begin tests_failed++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, if_id_pc4, 32'(4*(i+1))); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
            tests_run += 3;
            if (pc_out !== 32'h8)                begin tests_failed++; $display("FAIL stall_pc[%0d] got %h exp 8", i, pc_out); end
            if (if_id_instr !== 32'h1000_0001)   begin tests_failed++; $display("FAIL stall_instr[%0d] got %h exp 10000001", i, if_id_instr); end
            if (if_id_pc4 !== 32'h8)             begin tests_failed++; $display("FAIL stall_pc4[%0d] got %h exp 8", i, if_id_pc4); end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        tests_run += 2;
        if (pc_out !== 32'hC)                begin tests_failed++; $display("FAIL stall_resume_pc got %h exp c", pc_out); end
        if (if_id_instr !== 32'h1000_0002)   begin tests_failed++; $display("FAIL stall_resume_instr got %h exp 10000002", if_id_instr); end
    endtask

    task automatic test_branch();
        // Stall is also high: redirect must still win.
        step(1'b1, 1'b1, 32'h40, 1'b0, 26'h0);
        tests_run += 4;
        if (pc_out !== 32'h40)      begin tests_failed++; $display("FAIL br_pc got %h exp 40", pc_out); end
        if (if_id_valid !== 1'b0)   begin tests_failed++; $display("FAIL br_bubble_valid got %b exp 0", if_id_valid); end
        if (if_id_instr !== 32'h0)  begin tests_failed++; $display("FAIL br_bubble_instr got %h exp 0", if_id_instr); end
        if (if_id_pc4 !== 32'h0)    begin tests_failed++; $display("FAIL br_bubble_pc4 got %h exp 0", if_id_pc4); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        tests_run += 4;
        if (pc_out !== 32'h44)              begin tests_failed++; $display("FAIL br_next_pc got %h exp 44", pc_out); end
        if (if_id_valid !== 1'b1)           begin tests_failed++; $display("FAIL br_tgt_valid got %b exp 1", if_id_valid); end
        if (if_id_instr !== 32'h1000_0010)  begin tests_failed++; $display("FAIL br_tgt_instr got %h exp 10000010", if_id_instr); end
        if (if_id_pc4 !== 32'h44)           begin tests_failed++; $display("FAIL br_tgt_pc4 got %h exp 44", if_id_pc4); end
    endtask

    task automatic test_jump();
        step(1'b0, 1'b1, 32'h1000_0004, 1'b0, 26'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        tests_run += 1;
        if (if_id_pc4 !== 32'h1000_0008) begin tests_failed++; $display("FAIL jmp_setup_pc4 got %h exp 10000008", if_id_pc4); end
        step(1'b0, 1'b1, 32'h0000_0043, 1'b1, 26'h0000010);
        tests_run += 3;
        if (pc_out !== 32'h1000_0040)  begin tests_failed++; $display("FAIL jmp_pc got %h exp 10000040", pc_out); end
        if (misalign_err !== 1'b0)     begin tests_failed++; $display("FAIL jmp_err got %b exp 0", misalign_err); end
        if (if_id_valid !== 1'b0)      begin tests_failed++; $display("FAIL jmp_bubble got %b exp 0", if_id_valid); end
    endtask

    task automatic test_misalign();
        step(1'b0, 1'b1, 32'h42, 1'b0, 26'h0);
        tests_run += 2;
        if (pc_out !== 32'h40)       begin tests_failed++; $display("FAIL mis_pc got %h exp 40", pc_out); end
        if (misalign_err !== 1'b1)   begin tests_failed++; $display("FAIL mis_set got %b exp 1", misalign_err); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
            tests_run += 1;
            if (misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky[%0d] got %b exp 1", i, misalign_err); end
        end
        rst_n = 1'b0; model_reset(); #1;
        tests_run += 1;
        if (misalign_err !== 1'b0)   begin tests_failed++; $display("FAIL mis_clear got %b exp 0", misalign_err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_and_async_reset();
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        tests_run += 3;
        if (pc_out !== 32'h0)               begin tests_failed++; $display("FAIL wrap_pc got %h exp 0", pc_out); end
        if (if_id_pc4 !== 32'h0)            begin tests_failed++; $display("FAIL wrap_pc4 got %h exp 0", if_id_pc4); end
        if (if_id_instr !== 32'h4FFF_FFFF)  begin tests_failed++; $display("FAIL wrap_instr got %h exp 4fffffff", if_id_instr); end
        step(1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
        stall = 1'b1;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        tests_run += 4;
        if (pc_out !== 32'h0)       begin tests_failed++; $display("FAIL areset_pc got %h exp 0", pc_out); end
        if (if_id_valid !== 1'b0)   begin tests_failed++; $display("FAIL areset_valid got %b exp 0", if_id_valid); end
        if (if_id_instr !== 32'h0)  begin tests_failed++; $display("FAIL areset_instr got %h exp 0", if_id_instr); end
        if (if_id_pc4 !== 32'h0)    begin tests_failed++; $display("FAIL areset_pc4 got %h exp 0", if_id_pc4); end
        stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic        st, br, j;
        logic [31:0] bt;
        logic [25:0] ji;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            j  = ($urandom_range(0, 15) == 0);
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            ji = 26'($urandom);
            step(st, br, bt, j, ji);
            tests_run += 1;
            if (pc_out !== m_pc || if_id_valid !== m_valid || if_id_instr !== m_instr ||
                if_id_pc4 !== m_pc4 || misalign_err !== m_err) begin
                tests_failed++;
                $display("FAIL rand[%0d] got pc=%h v=%b i=%h p4=%h e=%b exp pc=%h v=%b i=%h p4=%h e=%b",
                         i, pc_out, if_id_valid, if_id_instr, if_id_pc4, misalign_err,
                         m_pc, m_valid, m_instr, m_pc4, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump();
        test_misalign();
        test_wrap_and_async_reset();
        apply_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
